// File: rtl/game_flow_if.sv
// Signal bundle between the Pac-Man top level and the game-flow sequencer.
// The sequencer sits on the slave side; the top level (or a bench) drives the master side.
interface game_flow_if #(
    parameter int NUM_GHOSTS = 2,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int LIVES_W    = 3,
    parameter int LEVEL_W    = 2
);
    logic                      start;
    logic                      pause_req;
    logic [X_W-1:0]            pac_x;
    logic [Y_W-1:0]            pac_y;
    logic [NUM_GHOSTS*X_W-1:0] ghost_x;
    logic [NUM_GHOSTS*Y_W-1:0] ghost_y;
    logic [15:0]               pills_left;
    logic                      sprite_reset;
    logic                      map_wr_reset;
    logic                      ghost_enable;
    logic [LIVES_W-1:0]        lives;
    logic [LEVEL_W-1:0]        level;
    logic [NUM_GHOSTS-1:0]     hit_vec;
    logic                      game_over;

    modport master (
        output start, pause_req, pac_x, pac_y, ghost_x, ghost_y, pills_left,
        input  sprite_reset, map_wr_reset, ghost_enable, lives, level, hit_vec, game_over
    );

    modport slave (
        input  start, pause_req, pac_x, pac_y, ghost_x, ghost_y, pills_left,
        output sprite_reset, map_wr_reset, ghost_enable, lives, level, hit_vec, game_over
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: ghost collision detect, lives, resume delay, level progression
// and pause, driving the sprite/map-writer resets and ghost enable.
module game_flow_ctrl #(
    parameter int NUM_GHOSTS    = 2,
    parameter int X_W           = 6,
    parameter int Y_W           = 5,
    parameter int LIVES_INIT    = 3,
    parameter int LIVES_W       = 3,
    parameter int MAX_LEVEL     = 4,
    parameter int RESUME_CYCLES = 250000000,
    localparam int LEVEL_W      = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    game_flow_if.slave    bus
);
    localparam int                 TIMER_W    = $clog2(RESUME_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESUME_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL - 1);
    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

    typedef enum logic [2:0] {
        S_IDLE, S_PLAY, S_PAUSE, S_RESUME, S_LEVEL_UP, S_OVER
    } state_t;

    typedef struct packed {
        logic sprite_reset;
        logic map_wr_reset;
        logic ghost_enable;
        logic game_over;
    } ctrl_t;

    // Output pattern for each state; applied alongside every state update so the
    // control outputs are registered and always match the state register.
    function automatic ctrl_t decode(input state_t s);
        case (s)
            S_IDLE:     decode = '{1'b1, 1'b1, 1'b0, 1'b0};
            S_PLAY:     decode = '{1'b0, 1'b0, 1'b1, 1'b0};
            S_RESUME:   decode = '{1'b1, 1'b0, 1'b0, 1'b0};
            S_LEVEL_UP: decode = '{1'b1, 1'b1, 1'b0, 1'b0};
            S_OVER:     decode = '{1'b0, 1'b0, 1'b0, 1'b1};
            default:    decode = '{1'b0, 1'b0, 1'b0, 1'b0};
        endcase
    endfunction

    state_t                 state;
    ctrl_t                  ctrl_q;
    logic [TIMER_W-1:0]     timer;
    logic [LIVES_W-1:0]     lives_q;
    logic [LEVEL_W-1:0]     level_q;
    logic [NUM_GHOSTS-1:0]  hit_q;
    logic [NUM_GHOSTS-1:0]  coll;
    logic                   any_coll;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        coll = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            coll[i] = (bus.ghost_x[i*X_W +: X_W] == bus.pac_x) &&
                      (bus.ghost_y[i*Y_W +: Y_W] == bus.pac_y);
        end
    end

    assign any_coll = |coll;

    // NOTE: sequential state uses non-blocking assignments so every register sees
    // the pre-edge values of the others.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ctrl_q  <= decode(S_IDLE);
            timer   <= '0;
            lives_q <= LIVES_LOAD;
            level_q <= '0;
            hit_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_PLAY;
                        ctrl_q  <= decode(S_PLAY);
                        lives_q <= LIVES_LOAD;
                        level_q <= '0;
                    end
                end

                S_PLAY: begin
                    // A collision outranks a cleared map in the same cycle.
                    if (any_coll) begin
                        hit_q <= coll;
                        if (lives_q > LIVES_W'(1)) begin
                            state   <= S_RESUME;
                            ctrl_q  <= decode(S_RESUME);
                            lives_q <= lives_q - LIVES_W'(1);
                            timer   <= TIMER_LOAD;
                        end else begin
                            state   <= S_OVER;
                            ctrl_q  <= decode(S_OVER);
                            lives_q <= '0;
                        end
                    end else if (bus.pills_left == 16'd0) begin
                        state  <= S_LEVEL_UP;
                        ctrl_q <= decode(S_LEVEL_UP);
                        timer  <= TIMER_LOAD;
                        if (level_q != LEVEL_TOP) level_q <= level_q + LEVEL_W'(1);
                    end else if (bus.pause_req) begin
                        state  <= S_PAUSE;
                        ctrl_q <= decode(S_PAUSE);
                    end
                end

                S_PAUSE: begin
                    if (!bus.pause_req) begin
                        state  <= S_PLAY;
                        ctrl_q <= decode(S_PLAY);
                    end
                end

                S_RESUME, S_LEVEL_UP: begin
                    if (timer == '0) begin
                        state  <= S_PLAY;
                        ctrl_q <= decode(S_PLAY);
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                S_OVER: begin
                    // start must drop before a new game can begin.
                    if (!bus.start) begin
                        state  <= S_IDLE;
                        ctrl_q <= decode(S_IDLE);
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    ctrl_q <= decode(S_IDLE);
                end
            endcase
        end
    end

    assign bus.sprite_reset = ctrl_q.sprite_reset;
    assign bus.map_wr_reset = ctrl_q.map_wr_reset;
    assign bus.ghost_enable = ctrl_q.ghost_enable;
    assign bus.game_over    = ctrl_q.game_over;
    assign bus.lives        = lives_q;
    assign bus.level        = level_q;
    assign bus.hit_vec      = hit_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: lives, resume hold, level-up, pause, game over, reset.
module tb_game_flow_ctrl;
    localparam int NUM_GHOSTS = 2;
    localparam int X_W        = 6;
    localparam int Y_W        = 5;
    localparam int LIVES_W    = 3;
    localparam int LEVEL_W    = 2;
    localparam int HOLD       = 8;

    // Expected {sprite_reset, map_wr_reset, ghost_enable, game_over} per state.
    localparam logic [3:0] C_IDLE   = 4'b1100;
    localparam logic [3:0] C_PLAY   = 4'b0010;
    localparam logic [3:0] C_PAUSE  = 4'b0000;
    localparam logic [3:0] C_RESUME = 4'b1000;
    localparam logic [3:0] C_LVLUP  = 4'b1100;
    localparam logic [3:0] C_OVER   = 4'b0001;

    logic CLOCK_50 = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    game_flow_if #(
        .NUM_GHOSTS(NUM_GHOSTS), .X_W(X_W), .Y_W(Y_W), .LIVES_W(LIVES_W), .LEVEL_W(LEVEL_W)
    ) bus ();

    game_flow_ctrl #(
        .NUM_GHOSTS(NUM_GHOSTS), .X_W(X_W), .Y_W(Y_W), .LIVES_INIT(3), .LIVES_W(LIVES_W),
        .MAX_LEVEL(4), .RESUME_CYCLES(HOLD)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    wire [3:0] ctrl = {bus.sprite_reset, bus.map_wr_reset, bus.ghost_enable, bus.game_over};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Checks ctrl on n consecutive negedges, leaving the bench n negedges later.
    task automatic expect_hold(input string tag, input logic [3:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(ctrl), 32'(exp));
            @(negedge CLOCK_50);
        end
    endtask

    task automatic ghosts_away();
        bus.ghost_x = {6'd0, 6'd1};
        bus.ghost_y = {5'd0, 5'd1};
    endtask

    task automatic ghost_on_pac(input int g);
        ghosts_away();
        if (g == 0) begin
            bus.ghost_x[X_W-1:0] = 6'd10;
            bus.ghost_y[Y_W-1:0] = 5'd5;
        end else begin
            bus.ghost_x[2*X_W-1:X_W] = 6'd10;
            bus.ghost_y[2*Y_W-1:Y_W] = 5'd5;
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.pause_req  = 1'b0;
        bus.pac_x      = 6'd10;
        bus.pac_y      = 5'd5;
        bus.pills_left = 16'd50;
        ghosts_away();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
        check("reset_lives", 32'(bus.lives), 32'd3);
        check("reset_level", 32'(bus.level), 32'd0);
        check("reset_hit", 32'(bus.hit_vec), 32'd0);

        reset_n   = 1'b1;
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        check("start_play", 32'(ctrl), 32'(C_PLAY));

        // First collision: ghost 1.
        ghost_on_pac(1);
        @(negedge CLOCK_50);
        ghosts_away();
        check("hit1_lives", 32'(bus.lives), 32'd2);
        check("hit1_vec", 32'(bus.hit_vec), 32'b10);
        expect_hold("hit1_resume", C_RESUME, HOLD);
        check("hit1_back_play", 32'(ctrl), 32'(C_PLAY));

        // Second collision: ghost 0.
        ghost_on_pac(0);
        @(negedge CLOCK_50);
        ghosts_away();
        check("hit2_lives", 32'(bus.lives), 32'd1);
        check("hit2_vec", 32'(bus.hit_vec), 32'b01);
        expect_hold("hit2_resume", C_RESUME, HOLD);
        check("hit2_back_play", 32'(ctrl), 32'(C_PLAY));

        // Third collision ends the game; ghost left on pac and start held high.
        ghost_on_pac(1);
        @(negedge CLOCK_50);
        check("over_lives", 32'(bus.lives), 32'd0);
        check("over_vec", 32'(bus.hit_vec), 32'b10);
        expect_hold("over_hold", C_OVER, 4);
        check("over_lives_held", 32'(bus.lives), 32'd0);
        ghosts_away();
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        check("over_to_idle", 32'(ctrl), 32'(C_IDLE));
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        check("restart_play", 32'(ctrl), 32'(C_PLAY));
        check("restart_lives", 32'(bus.lives), 32'd3);

        // Collision and cleared map together: collision wins.
        bus.pills_left = 16'd0;
        ghost_on_pac(0);
        @(negedge CLOCK_50);
        bus.pills_left = 16'd50;
        ghosts_away();
        check("prio_lives", 32'(bus.lives), 32'd2);
        check("prio_level", 32'(bus.level), 32'd0);
        check("prio_vec", 32'(bus.hit_vec), 32'b01);
        expect_hold("prio_resume", C_RESUME, HOLD);
        check("prio_back_play", 32'(ctrl), 32'(C_PLAY));

        // Four level clears; level saturates at 3.
        for (int k = 1; k <= 4; k++) begin
            bus.pills_left = 16'd0;
            @(negedge CLOCK_50);
            bus.pills_left = 16'd50;
            check($sformatf("lvl%0d_level", k), 32'(bus.level), 32'(k > 3 ? 3 : k));
            check($sformatf("lvl%0d_lives", k), 32'(bus.lives), 32'd2);
            expect_hold($sformatf("lvl%0d_hold", k), C_LVLUP, HOLD);
            check($sformatf("lvl%0d_play", k), 32'(ctrl), 32'(C_PLAY));
        end

        // Pause, then a ghost lands on pac while paused: ignored.
        bus.pause_req = 1'b1;
        @(negedge CLOCK_50);
        ghost_on_pac(0);
        expect_hold("pause_hold", C_PAUSE, 4);
        check("pause_lives", 32'(bus.lives), 32'd2);
        ghosts_away();
        bus.pause_req = 1'b0;
        @(negedge CLOCK_50);
        check("unpause_play", 32'(ctrl), 32'(C_PLAY));

        // Reset in the middle of RESUME.
        ghost_on_pac(1);
        @(negedge CLOCK_50);
        ghosts_away();
        check("mid_lives", 32'(bus.lives), 32'd1);
        expect_hold("mid_resume", C_RESUME, 3);
        reset_n   = 1'b0;
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        check("mid_rst_ctrl", 32'(ctrl), 32'(C_IDLE));
        check("mid_rst_lives", 32'(bus.lives), 32'd3);
        check("mid_rst_level", 32'(bus.level), 32'd0);
        check("mid_rst_hit", 32'(bus.hit_vec), 32'd0);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        check("post_rst_idle", 32'(ctrl), 32'(C_IDLE));

        // Fresh game after reset gets a full resume hold again.
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        ghost_on_pac(0);
        @(negedge CLOCK_50);
        ghosts_away();
        check("post_rst_lives", 32'(bus.lives), 32'd2);
        expect_hold("post_rst_resume", C_RESUME, HOLD);
        check("post_rst_play", 32'(ctrl), 32'(C_PLAY));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
